uart_tx_master: RTL and testbench
=================================

Name: uart_tx_master

Overview:
- WISHBONE master that drains a byte FIFO into the MiniUART slave's transmit path.
- Producer (CPU bridge or console logic) pushes bytes into the FIFO. The block polls the UART line status register and writes each byte to the data register only when the transmitter is idle.
- Optionally programs the baud divisors (DIVR/DIVT) before streaming.
- Sits between the console/bridge logic and the MiniUART WISHBONE port.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes.
- GUARD, 4, idle cycles after each data write before the next LSR poll, covering the transmitter's load-to-busy latency. Legal range 2..15.
- TS_BIT, 5, LSR bit that indicates transmitter idle.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  asynchronous, active-high reset
- push  in  1  enqueue din this cycle
- din  in  8  byte to transmit
- full  out  1  FIFO full; a push while full is dropped
- empty  out  1  FIFO empty and no byte in flight
- count  out  DEPTH_LOG2+1  FIFO occupancy
- cfg_req  in  1  pulse: program divisors with cfg_divr/cfg_divt
- cfg_divr  in  16  receive divisor value
- cfg_divt  in  16  transmit divisor value
- cfg_busy  out  1  high from cfg_req acceptance until the DIVT write is acknowledged
- ADD_O  out  3  WISHBONE address [4:2]
- DAT_O  out  32  WISHBONE write data
- DAT_I  in  32  WISHBONE read data
- STB_O  out  1  strobe
- WE_O  out  1  write enable
- ACK_I  in  1  acknowledge

Behaviour:
- Reset values (asynchronous, on RST_I high): state=IDLE; STB_O=0, WE_O=0, ADD_O=0, DAT_O=0; FIFO pointers=0; count=0; full=0; empty=1; cfg_busy=0; guard counter=0. Reset mid-transaction aborts the bus cycle with no completion and discards FIFO contents.
- FIFO: circular buffer with DEPTH_LOG2-bit read/write pointers plus wrap bit.
  - Push while full: ignored.
  - Simultaneous push and pop: allowed, including when full (count unchanged).
  - Pop happens only on the ACK of a data write.
- Bus cycle rules:
  - STB_O, WE_O, ADD_O and DAT_O are registered and held stable until the cycle in which ACK_I=1.
  - STB_O falls in the cycle after the ACK.
  - ACK may arrive combinationally in the same cycle as STB_O.
- Address offsets use the shared UART header macros OFF_UART_DATA, OFF_UART_LSR, OFF_UART_DIVR and OFF_UART_DIVT.
- State machine:
  - IDLE: cfg_req has priority.
    - If cfg_req: capture cfg_divr/cfg_divt, set cfg_busy, go to CFG_R.
    - Else if FIFO not empty: go to POLL.
    - A cfg_req arriving while not in IDLE is latched as pending and served at the next IDLE visit.
  - CFG_R: write {16'b0,cfg_divr} to OFF_UART_DIVR. On ACK, go to CFG_T.
  - CFG_T: write {16'b0,cfg_divt} to OFF_UART_DIVT. On ACK, clear cfg_busy and go to IDLE.
  - POLL: read OFF_UART_LSR. On ACK:
    - If DAT_I[TS_BIT]=1, go to WRITE.
    - Else go to POLL_GAP (1 idle cycle, STB_O=0), then back to POLL.
  - WRITE: write {24'b0, fifo head} to OFF_UART_DATA. On ACK, pop the FIFO, load the guard counter with GUARD, go to GUARD.
  - GUARD: decrement the counter each cycle. At 0, go to IDLE.
- empty=1 only when the FIFO is empty and state is neither WRITE nor GUARD.
- Throughput: at most one byte per (2 + GUARD + UART frame time) cycles. Bytes are never reordered or duplicated.
- DAT_I bits other than TS_BIT are ignored.

Decomposition:
- Reuse the shared UART header for the offset macros and BAUD_* constants.
- State encodings are local defines, added to the header only if other masters need them.
- One sub-module, uart_tx_fifo (synchronous byte FIFO with push/pop/full/empty/count). The FSM and bus logic stay in the top.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 with an LSR model returning ts=1. Required: three data writes, DAT_O = 0x00000041, 0x00000042, 0x00000043 in order, each preceded by an LSR read, with ≥GUARD idle cycles between them. empty returns to 1 afterwards.
- Hold LSR ts=0 for 20 polls, then set it to 1. Required: repeated LSR reads separated by one idle cycle, no data write while ts=0, the write follows the first ts=1 ACK.
- Push 17 bytes with DEPTH_LOG2=4 while ts=0. Required: full=1 after 16, the 17th is dropped, count=16. Releasing ts drains exactly the 16 bytes in order.
- cfg_req with cfg_divr=0x0A2C, cfg_divt=0x0A2C while FIFO data is pending and the state is POLL. Required: the current byte completes, then DIVR and DIVT writes occur before the next byte, and cfg_busy falls on the DIVT ACK.
- Assert RST_I while STB_O is high in WRITE. Required: STB_O=0 immediately, count=0, empty=1, and no data write after reset releases.
- Slave with delayed ACK (3 cycles) and push in the same cycle as pop while full. Required: outputs stable until ACK, count unchanged, no byte lost.

Source files
------------

// File: rtl/uart_tx_master_pkg.sv
// Shared types and MiniUART register offsets for the UART transmit master.
package uart_tx_master_pkg;

  localparam logic [2:0] OFF_UART_DATA = 3'd0;
  localparam logic [2:0] OFF_UART_LSR  = 3'd1;
  localparam logic [2:0] OFF_UART_DIVR = 3'd2;
  localparam logic [2:0] OFF_UART_DIVT = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_R,
    ST_CFG_T,
    ST_POLL,
    ST_POLL_GAP,
    ST_WRITE,
    ST_GUARD
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
  } wb_req_t;

  function automatic wb_req_t wb_rd(input logic [2:0] adr);
    wb_req_t r;
    r.we  = 1'b0;
    r.adr = adr;
    r.dat = 32'h0;
    return r;
  endfunction

  function automatic wb_req_t wb_wr(input logic [2:0] adr, input logic [31:0] dat);
    wb_req_t r;
    r.we  = 1'b1;
    r.adr = adr;
    r.dat = dat;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO, 2**DEPTH_LOG2 deep, head visible combinationally; push while full
// is dropped unless a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [7:0]            i_din,
  input  logic                  i_pop,
  output logic [7:0]            o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_push;
  logic                w_pop;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = o_count[DEPTH_LOG2];
  assign o_head  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_tx_master.sv
// WISHBONE master draining a byte FIFO into the MiniUART: polls LSR, writes DATA
// when the transmitter is idle, optionally programs DIVR/DIVT first.
module uart_tx_master
  import uart_tx_master_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int GUARD      = 4,
  parameter int TS_BIT     = 5
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  push,
  input  logic [7:0]            din,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  input  logic                  cfg_req,
  input  logic [15:0]           cfg_divr,
  input  logic [15:0]           cfg_divt,
  output logic                  cfg_busy,
  output logic [2:0]            ADD_O,
  output logic [31:0]           DAT_O,
  input  logic [31:0]           DAT_I,
  output logic                  STB_O,
  output logic                  WE_O,
  input  logic                  ACK_I
);

  state_t      r_state;
  wb_req_t     r_req;
  logic        r_stb;
  logic        r_cfg_busy;
  logic        r_cfg_pend;
  logic [15:0] r_divr;
  logic [15:0] r_divt;
  logic [3:0]  r_guard;

  logic        w_pop;
  logic        w_fifo_empty;
  logic [7:0]  w_head;
  logic        w_ts;

  // Masking keeps every DAT_I bit in the cone; only TS_BIT matters.
  assign w_ts  = |(DAT_I & (32'd1 << TS_BIT));
  assign w_pop = (r_state == ST_WRITE) && r_stb && ACK_I;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .i_clk   (CLK_I),
    .i_rst   (RST_I),
    .i_push  (push),
    .i_din   (din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (full),
    .o_empty (w_fifo_empty),
    .o_count (count)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state    <= ST_IDLE;
      r_req      <= '0;
      r_stb      <= 1'b0;
      r_cfg_busy <= 1'b0;
      r_cfg_pend <= 1'b0;
      r_divr     <= '0;
      r_divt     <= '0;
      r_guard    <= '0;
    end else begin
      if (cfg_req) begin
        r_divr <= cfg_divr;
        r_divt <= cfg_divt;
        if (r_state != ST_IDLE) r_cfg_pend <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (cfg_req || r_cfg_pend) begin
            r_cfg_pend <= 1'b0;
            r_cfg_busy <= 1'b1;
            r_state    <= ST_CFG_R;
          end else if (!w_fifo_empty) begin
            r_stb   <= 1'b1;
            r_req   <= wb_rd(OFF_UART_LSR);
            r_state <= ST_POLL;
          end
        end
        ST_CFG_R: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_req <= wb_wr(OFF_UART_DIVR, {16'b0, r_divr});
          end else if (ACK_I) begin
            r_stb   <= 1'b0;
            r_state <= ST_CFG_T;
          end
        end
        ST_CFG_T: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_req <= wb_wr(OFF_UART_DIVT, {16'b0, r_divt});
          end else if (ACK_I) begin
            r_stb      <= 1'b0;
            r_cfg_busy <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        ST_POLL: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_req <= wb_rd(OFF_UART_LSR);
          end else if (ACK_I) begin
            r_stb   <= 1'b0;
            r_state <= w_ts ? ST_WRITE : ST_POLL_GAP;
          end
        end
        // Strobe is re-raised on leaving the gap so polls sit exactly one cycle apart.
        ST_POLL_GAP: begin
          r_stb   <= 1'b1;
          r_req   <= wb_rd(OFF_UART_LSR);
          r_state <= ST_POLL;
        end
        ST_WRITE: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_req <= wb_wr(OFF_UART_DATA, {24'b0, w_head});
          end else if (ACK_I) begin
            r_stb   <= 1'b0;
            r_guard <= 4'(GUARD);
            r_state <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (r_guard == 4'd0) r_state <= ST_IDLE;
          else                 r_guard <= r_guard - 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign STB_O    = r_stb;
  assign WE_O     = r_req.we;
  assign ADD_O    = r_req.adr;
  assign DAT_O    = r_req.dat;
  assign cfg_busy = r_cfg_busy;
  assign empty    = w_fifo_empty && (r_state != ST_WRITE) && (r_state != ST_GUARD);

endmodule

// File: tb/tb_uart_tx_master.sv
// Directed bench for uart_tx_master with a MiniUART slave model (programmable ACK delay, LSR ts).
module tb_uart_tx_master;
  import uart_tx_master_pkg::*;

  localparam int DL  = 4;
  localparam int GRD = 4;
  localparam int TSB = 5;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        push = 1'b0;
  logic [7:0]  din = 8'h0;
  logic        full, empty, cfg_busy, STB_O, WE_O, ACK_I;
  logic [DL:0] count;
  logic        cfg_req = 1'b0;
  logic [15:0] cfg_divr = 16'h0, cfg_divt = 16'h0;
  logic [2:0]  ADD_O;
  logic [31:0] DAT_O, DAT_I;

  uart_tx_master #(.DEPTH_LOG2(DL), .GUARD(GRD), .TS_BIT(TSB)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .push(push), .din(din), .full(full), .empty(empty),
    .count(count), .cfg_req(cfg_req), .cfg_divr(cfg_divr), .cfg_divt(cfg_divt),
    .cfg_busy(cfg_busy), .ADD_O(ADD_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Slave model: ACK after ack_dly cycles of strobe (0 = same cycle); junk in non-ts LSR bits.
  logic ts = 1'b1;
  int   ack_dly = 0;
  int   wcnt = 0;
  assign ACK_I = STB_O && (wcnt >= ack_dly);
  assign DAT_I = ts ? 32'h0000_0020 : 32'hFFFF_FFDF;
  always @(posedge CLK_I) begin
    if (!STB_O || ACK_I) wcnt <= 0;
    else                 wcnt <= wcnt + 1;
  end

  int cyc = 0;
  always @(posedge CLK_I) cyc <= cyc + 1;

  // Bus monitor, sampled mid-cycle.
  logic        q_we[$];
  logic [2:0]  q_adr[$];
  logic [31:0] q_dat[$];
  int          q_cyc[$];
  int          gq[$];
  int          low_run = 0, n_lsr0 = 0, bad_wr = 0, stab_err = 0;
  int          divt_cyc = 0, busy_fall_cyc = 0;
  logic [2:0]  last_adr = 3'd0;
  logic        stb_prev = 1'b0, prev_ack = 1'b0, busy_prev = 1'b0;
  logic [35:0] prev_out = '0;

  always @(negedge CLK_I) begin
    if (STB_O && ACK_I) begin
      q_we.push_back(WE_O);
      q_adr.push_back(ADD_O);
      q_dat.push_back(WE_O ? DAT_O : DAT_I);
      q_cyc.push_back(cyc);
      if (!WE_O && ADD_O == OFF_UART_LSR && !DAT_I[TSB]) n_lsr0++;
      if (WE_O && ADD_O == OFF_UART_DATA && !ts) bad_wr++;
      if (WE_O && ADD_O == OFF_UART_DIVT) divt_cyc = cyc;
    end
    if (STB_O && stb_prev && (prev_ack || {WE_O, ADD_O, DAT_O} != prev_out)) stab_err++;
    if (!STB_O) low_run++;
    else if (!stb_prev) begin
      if (!WE_O && ADD_O == OFF_UART_LSR && last_adr == OFF_UART_LSR) gq.push_back(low_run);
      low_run  = 0;
      last_adr = ADD_O;
    end
    if (busy_prev && !cfg_busy) busy_fall_cyc = cyc;
    busy_prev = cfg_busy;
    stb_prev  = STB_O;
    prev_ack  = STB_O && ACK_I;
    prev_out  = {WE_O, ADD_O, DAT_O};
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_I);
      #1;
    end
  endtask

  task automatic clear_log();
    q_we.delete(); q_adr.delete(); q_dat.delete(); q_cyc.delete(); gq.delete();
    n_lsr0 = 0; bad_wr = 0; stab_err = 0; divt_cyc = 0; busy_fall_cyc = 0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k;
    k = 0;
    while (!(empty && !STB_O && !cfg_busy) && k < lim) begin
      tick(1);
      k++;
    end
    chk({tag, "_done"}, 40'(k < lim), 40'd1);
  endtask

  task automatic chk_writes(input string tag, input logic [34:0] exp[$]);
    logic [34:0] got[$];
    foreach (q_we[i]) if (q_we[i]) got.push_back({q_adr[i], q_dat[i]});
    chk({tag, "_nwr"}, 40'(got.size()), 40'(exp.size()));
    foreach (exp[i])
      chk($sformatf("%s_wr%0d", tag, i), (i < got.size()) ? 40'(got[i]) : 40'hFF_FFFF_FFFF, 40'(exp[i]));
  endtask

  task automatic push_byte(input logic [7:0] b);
    push = 1'b1;
    din  = b;
    tick(1);
    push = 1'b0;
  endtask

  logic [34:0] e[$];
  int          k, w, gmin, gmax;
  logic        ok;

  initial begin
    // Reset values
    tick(3);
    chk("rst_stb", 40'(STB_O), 40'd0);
    chk("rst_we", 40'(WE_O), 40'd0);
    chk("rst_adr", 40'(ADD_O), 40'd0);
    chk("rst_dat", 40'(DAT_O), 40'd0);
    chk("rst_count", 40'(count), 40'd0);
    chk("rst_full", 40'(full), 40'd0);
    chk("rst_empty", 40'(empty), 40'd1);
    chk("rst_busy", 40'(cfg_busy), 40'd0);
    RST_I = 1'b0;
    tick(2);
    chk("idle_stb", 40'(STB_O), 40'd0);

    // Three bytes with a ready transmitter
    clear_log();
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    wait_done("t1", 500);
    e = {};
    e.push_back({OFF_UART_DATA, 32'h41});
    e.push_back({OFF_UART_DATA, 32'h42});
    e.push_back({OFF_UART_DATA, 32'h43});
    chk_writes("t1", e);
    for (int i = 0; i < q_we.size(); i++) begin
      if (q_we[i]) begin
        ok = (i > 0) && !q_we[i-1] && (q_adr[i-1] == OFF_UART_LSR) && q_dat[i-1][TSB];
        chk("t1_lsr_before_wr", 40'(ok), 40'd1);
        if (i + 1 < q_we.size())
          chk("t1_guard_gap", 40'((q_cyc[i+1] - q_cyc[i] - 1) >= GRD), 40'd1);
      end
    end
    chk("t1_empty", 40'(empty), 40'd1);

    // Transmitter busy for 20 polls
    clear_log();
    ts = 1'b0;
    push_byte(8'h55);
    k = 0;
    while (n_lsr0 < 20 && k < 300) begin tick(1); k++; end
    chk("t2_polls_timeout", 40'(k < 300), 40'd1);
    chk("t2_no_wr_while_busy", 40'(q_we.size() > 0 && q_we[q_we.size()-1]), 40'd0);
    ts = 1'b1;
    wait_done("t2", 200);
    chk("t2_bad_wr", 40'(bad_wr), 40'd0);
    chk("t2_n_lsr0", 40'(n_lsr0), 40'd20);
    gmin = 99; gmax = 0;
    foreach (gq[i]) begin
      if (gq[i] < gmin) gmin = gq[i];
      if (gq[i] > gmax) gmax = gq[i];
    end
    chk("t2_gap_cnt", 40'(gq.size()), 40'd20);
    chk("t2_gap_min", 40'(gmin), 40'd1);
    chk("t2_gap_max", 40'(gmax), 40'd1);
    e = {};
    e.push_back({OFF_UART_DATA, 32'h55});
    chk_writes("t2", e);
    w = -1;
    foreach (q_we[i]) if (q_we[i] && w < 0) w = i;
    ok = (w >= 2) && q_dat[w-1][TSB] && !q_dat[w-2][TSB];
    chk("t2_wr_after_first_ts", 40'(ok), 40'd1);

    // Overfill while the transmitter is busy
    clear_log();
    ts = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push = 1'b1;
      din  = 8'h60 + 8'(i);
      tick(1);
      if (i == 15) begin
        chk("t3_full_16", 40'(full), 40'd1);
        chk("t3_count_16", 40'(count), 40'd16);
      end
    end
    push = 1'b0;
    tick(1);
    chk("t3_count_17", 40'(count), 40'd16);
    chk("t3_full_17", 40'(full), 40'd1);
    ts = 1'b1;
    wait_done("t3", 2000);
    e = {};
    for (int i = 0; i < 16; i++) e.push_back({OFF_UART_DATA, 32'h60 + 32'(i)});
    chk_writes("t3", e);

    // Divisor request while polling
    clear_log();
    ts = 1'b0;
    push_byte(8'hA1); push_byte(8'hA2);
    tick(8);
    cfg_req = 1'b1; cfg_divr = 16'h0A2C; cfg_divt = 16'h0A2C;
    tick(1);
    cfg_req = 1'b0; cfg_divr = 16'h0; cfg_divt = 16'h0;
    tick(5);
    ts = 1'b1;
    wait_done("t4", 500);
    e = {};
    e.push_back({OFF_UART_DATA, 32'hA1});
    e.push_back({OFF_UART_DIVR, 32'h0000_0A2C});
    e.push_back({OFF_UART_DIVT, 32'h0000_0A2C});
    e.push_back({OFF_UART_DATA, 32'hA2});
    chk_writes("t4", e);
    chk("t4_busy_fall", 40'(busy_fall_cyc - divt_cyc), 40'd1);

    // Reset in the middle of a data write
    clear_log();
    ack_dly = 5;
    push_byte(8'h77); push_byte(8'h78);
    k = 0;
    while (!(STB_O && WE_O && ADD_O == OFF_UART_DATA) && k < 60) begin tick(1); k++; end
    chk("t5_reach_write", 40'(k < 60), 40'd1);
    RST_I = 1'b1;
    #1;
    chk("t5_stb", 40'(STB_O), 40'd0);
    chk("t5_count", 40'(count), 40'd0);
    chk("t5_empty", 40'(empty), 40'd1);
    tick(2);
    clear_log();
    RST_I = 1'b0;
    tick(40);
    chk("t5_no_bus", 40'(q_we.size()), 40'd0);

    // Slow slave; push during the pop of a full FIFO
    clear_log();
    ack_dly = 3;
    ts = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'h90 + 8'(i));
    chk("t6_full", 40'(full), 40'd1);
    ts = 1'b1;
    k = 0;
    while (!(STB_O && WE_O && ADD_O == OFF_UART_DATA && ACK_I) && k < 100) begin tick(1); k++; end
    chk("t6_reach_ack", 40'(k < 100), 40'd1);
    chk("t6_full_at_pop", 40'(full), 40'd1);
    push = 1'b1; din = 8'h80;
    tick(1);
    push = 1'b0;
    chk("t6_count", 40'(count), 40'd16);
    wait_done("t6", 3000);
    e = {};
    for (int i = 0; i < 16; i++) e.push_back({OFF_UART_DATA, 32'h90 + 32'(i)});
    e.push_back({OFF_UART_DATA, 32'h80});
    chk_writes("t6", e);
    chk("t6_stable", 40'(stab_err), 40'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
